// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared display codes, segment constants and helpers
//
// Contents:
//   CODE_E / CODE_R / CODE_O / CODE_BLANK / CODE_ZERO  4-bit display codes
//   SEG_OFF                                            all segments dark (active-low)
//   is_blank_code()                                    true for codes that decode to blank
//   error_code()                                       nibble shown at a digit position in "Erro" mode

package display_pkg;

  localparam logic [3:0] CODE_ZERO  = 4'b0000;
  localparam logic [3:0] CODE_E     = 4'b1100;
  localparam logic [3:0] CODE_R     = 4'b1110;
  localparam logic [3:0] CODE_O     = 4'b1111;
  localparam logic [3:0] CODE_BLANK = 4'b1010;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  function automatic logic is_blank_code(input logic [3:0] code);
    return (code == 4'b1010) || (code == 4'b1011) || (code == 4'b1101);
  endfunction

  // "Erro" reads left to right on digits 3..0; wider banks blank the extra digits.
  function automatic logic [3:0] error_code(input int pos);
    case (pos)
      0:       return CODE_O;
      1, 2:    return CODE_R;
      3:       return CODE_E;
      default: return CODE_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/segment_decoder.sv
// rtl/segment_decoder.sv - 4-bit display code to active-low 7-segment pattern
//
// Ports:
//   code  in   4  display code (0-9, E, r, o; remaining codes blank)
//   seg   out  7  {a,b,c,d,e,f,g}, 0 = segment lit

module segment_decoder
  import display_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0:    seg = 7'b0000001;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      CODE_E:  seg = 7'b0110000;
      CODE_R:  seg = 7'b1111010;
      CODE_O:  seg = 7'b1100010;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed common-anode 7-segment bank driver
//
// Ports:
//   clock       in   1         system clock, rising edge
//   reset       in   1         synchronous, active-high
//   value       in   4*DIGITS  packed codes, nibble 0 = rightmost digit
//   load        in   1         strobe capturing value into the pending buffer
//   error       in   1         level; while high the bank shows "Erro"
//   segments    out  7         {a,b,c,d,e,f,g}, active-low
//   digit_sel   out  DIGITS    one-hot active-low digit enable, bit 0 = rightmost
//   frame_done  out  1         pulse in the last cycle of digit DIGITS-1's slot
//
// Build option: DISPLAY_SCANNER_ZERO_BLANK_EN enables leading-zero suppression.

module display_scanner
  import display_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int GUARD    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  error,
  output logic [6:0]            segments,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]    GUARD_CNT = CNT_W'(GUARD);
  localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [4*DIGITS-1:0] ALL_BLANK = {DIGITS{CODE_BLANK}};

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                pend_valid_q, pend_valid_d;
  logic [6:0]          segments_q, segments_d;
  logic [DIGITS-1:0]   digit_sel_q, digit_sel_d;
  logic                frame_done_q, frame_done_d;

  logic                at_slot_end;
  logic                at_frame_end;
  logic [4*DIGITS-1:0] shown_codes;
  logic [3:0]          nib;
  logic [3:0]          sel_code;
  logic [6:0]          dec_seg;
`ifdef DISPLAY_SCANNER_ZERO_BLANK_EN
  logic                lead;
`endif

  // Slot counter and digit index
  always_comb begin
    at_slot_end  = (cnt_q == CNT_LAST);
    at_frame_end = at_slot_end && (idx_q == IDX_LAST);
    cnt_d        = at_slot_end ? '0 : cnt_q + 1'b1;
    idx_d        = idx_q;
    if (at_slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Registered from the next counter state so the pulse lines up with
    // the cycle in which the counter itself sits at the frame end.
    frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
  end

  // Double buffering: display only ever changes on the frame-end edge
  always_comb begin
    disp_d       = disp_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (load) begin
      if (at_frame_end) begin
        disp_d       = value;
        pend_valid_d = 1'b0;
      end else begin
        pend_d       = value;
        pend_valid_d = 1'b1;
      end
    end else if (at_frame_end && pend_valid_q) begin
      disp_d       = pend_q;
      pend_valid_d = 1'b0;
    end
  end

  // Per-digit code actually shown: error substitution overrides the display
  // register without touching it, so dropping error restores it at once.
  always_comb begin
    shown_codes = '0;
    nib         = CODE_BLANK;
`ifdef DISPLAY_SCANNER_ZERO_BLANK_EN
    lead        = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = disp_q[4*i +: 4];
      shown_codes[4*i +: 4] = nib;
`ifdef DISPLAY_SCANNER_ZERO_BLANK_EN
      // lead stays set while every higher digit is zero or blank
      if ((i != 0) && lead && (nib == CODE_ZERO)) begin
        shown_codes[4*i +: 4] = CODE_BLANK;
      end
      lead = lead && ((nib == CODE_ZERO) || is_blank_code(nib));
`endif
      if (error) begin
        shown_codes[4*i +: 4] = error_code(i);
      end
    end
  end

  always_comb begin
    sel_code = CODE_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_code = shown_codes[4*i +: 4];
      end
    end
  end

  segment_decoder u_segment_decoder (
    .code (sel_code),
    .seg  (dec_seg)
  );

  // Outputs: anti-ghosting guard keeps every digit dark at slot start
  always_comb begin
    segments_d  = dec_seg;
    digit_sel_d = '1;
    if (cnt_q >= GUARD_CNT) begin
      for (int i = 0; i < DIGITS; i++) begin
        digit_sel_d[i] = !(idx_q == IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      disp_q       <= ALL_BLANK;
      pend_q       <= ALL_BLANK;
      pend_valid_q <= 1'b0;
      segments_q   <= SEG_OFF;
      digit_sel_q  <= '1;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      segments_q   <= segments_d;
      digit_sel_q  <= digit_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign segments   = segments_q;
  assign digit_sel  = digit_sel_q;
  assign frame_done = frame_done_q;

endmodule
